// File: rtl/p_pkg.sv
// Shared types and helpers for the unary decode pipeline.
package p_pkg;

    // Width of the optional admitted/rejected statistics counters.
    localparam int unsigned STATS_W = 32;

    // Widest level field needed (W up to 64 gives levels 0..63).
    localparam int unsigned LW_MAX = 6;

    // Width of the popcount result for a 64-bit operand.
    localparam int unsigned POP_W = 7;

    // Payload held in the result stage; level is truncated to LW at the port.
    typedef struct packed {
        logic              is_unary;
        logic              is_compl;
        logic [LW_MAX-1:0] level;
    } result_t;

    // Number of set bits in a word that has been zero-extended to 64 bits.
    function automatic logic [POP_W-1:0] popcount(input logic [63:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/p_unary_decode_pipe_admit.sv
// Combinational unary admission check: a word is unary when its normalised
// form is 0...01...1, i.e. normalised + 1 is a power of two.
module p_unary_decode_pipe_admit #(
    parameter int unsigned W                     = 16,
    parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b1
) (
    input  logic [W-1:0] i_x,
    output logic         o_admit_c,
    output logic         o_compl_c,
    output logic [W-1:0] o_xn_c
);

    logic         w_msb;
    logic [W-1:0] w_xn;
    logic [W-1:0] w_inc;
    logic         w_onehot;

    // Normalise, then test normalised + 1 for exactly one set bit.
    always_comb begin
        w_msb     = i_x[W-1];
        w_xn      = P_ADMIT_COMPLIMENT_EN ? (i_x ^ {W{w_msb}}) : i_x;
        w_inc     = w_xn + W'(1);
        w_onehot  = (w_inc != '0) && ((w_inc & (w_inc - W'(1))) == '0);
        o_admit_c = w_onehot & (P_ADMIT_COMPLIMENT_EN | ~w_msb);
        o_compl_c = o_admit_c & w_msb;
        o_xn_c    = w_xn;
    end

endmodule

// File: rtl/p_unary_decode_pipe.sv
// Two-stage valid/ready pipeline: S1 captures the raw word, S2 holds the
// admission decision and decoded level. Optional output-transfer statistics
// are built when P_UNARY_DECODE_STATS_EN is defined.
module p_unary_decode_pipe
    import p_pkg::*;
#(
    parameter int unsigned  W                     = 16,
    parameter bit           P_ADMIT_COMPLIMENT_EN = 1'b1,
    localparam int unsigned LW                    = $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_valid,
    input  logic [W-1:0]  i_x,
    output logic          o_ready,
    output logic          o_valid,
    output logic          o_is_unary,
    output logic          o_is_compl,
    output logic [LW-1:0] o_level,
    input  logic          i_ready
`ifdef P_UNARY_DECODE_STATS_EN
    ,
    input  logic               i_cnt_clr,
    output logic [STATS_W-1:0] o_cnt_adm,
    output logic [STATS_W-1:0] o_cnt_rej
`endif
);

    logic         r_v1;
    logic         r_v2;
    logic [W-1:0] r_x;
    result_t      r_s2;

    logic         w_adv1;
    logic         w_adv2;
    logic         w_admit;
    logic         w_compl;
    logic [W-1:0] w_xn;
    result_t      w_res;

    p_unary_decode_pipe_admit #(
        .W                     (W),
        .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
    ) u_admit (
        .i_x       (r_x),
        .o_admit_c (w_admit),
        .o_compl_c (w_compl),
        .o_xn_c    (w_xn)
    );

    // Stage advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        w_adv2 = ~r_v2 | i_ready;
        w_adv1 = ~r_v1 | w_adv2;
    end

    assign o_ready = w_adv1;

    // Decode S1 into the S2 payload; rejected words carry level 0.
    always_comb begin
        w_res          = '0;
        w_res.is_unary = w_admit;
        w_res.is_compl = w_compl;
        if (w_admit) begin
            w_res.level = LW_MAX'(LW'(popcount(64'(w_xn))));
        end
    end

    // S1: capture the raw word on an input transfer.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_v1 <= 1'b0;
            r_x  <= '0;
        end else if (w_adv1) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_x <= i_x;
            end
        end
    end

    // S2: register the decoded result; held stable while stalled.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2 <= w_res;
            end
        end
    end

    assign o_valid    = r_v2;
    assign o_is_unary = r_s2.is_unary;
    assign o_is_compl = r_s2.is_compl;
    assign o_level    = LW'(r_s2.level);

`ifdef P_UNARY_DECODE_STATS_EN
    logic               w_xfer;
    logic [STATS_W-1:0] r_cnt_adm;
    logic [STATS_W-1:0] r_cnt_rej;

    assign w_xfer = r_v2 & i_ready;

    // Saturating counts of admitted/rejected output transfers; clear wins.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_cnt_adm <= '0;
            r_cnt_rej <= '0;
        end else if (i_cnt_clr) begin
            r_cnt_adm <= '0;
            r_cnt_rej <= '0;
        end else if (w_xfer) begin
            if (r_s2.is_unary) begin
                if (r_cnt_adm != '1) begin
                    r_cnt_adm <= r_cnt_adm + STATS_W'(1);
                end
            end else begin
                if (r_cnt_rej != '1) begin
                    r_cnt_rej <= r_cnt_rej + STATS_W'(1);
                end
            end
        end
    end

    assign o_cnt_adm = r_cnt_adm;
    assign o_cnt_rej = r_cnt_rej;
`endif

endmodule

// File: tb/tb_p_unary_decode_pipe.sv
// Bench for p_unary_decode_pipe: two W=8 instances (compliment admission on
// and off) share one stimulus stream and are scored against a queue model.
// Define P_UNARY_DECODE_STATS_EN to also score the statistics counters.
module tb_p_unary_decode_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_v;
    logic       rdy_in;
    logic       cnt_clr;
    logic [7:0] in_x;

    logic       rdy [2];
    logic       ov  [2];
    logic       oun [2];
    logic       oco [2];
    logic [2:0] olv [2];

    int total = 0;
    int bad   = 0;

    logic [4:0] q [2][$];
    logic       stl  [2];
    logic [5:0] held [2];

`ifdef P_UNARY_DECODE_STATS_EN
    logic [31:0] cadm  [2];
    logic [31:0] crej  [2];
    logic [31:0] m_adm [2];
    logic [31:0] m_rej [2];
`endif

    always #5 clk = ~clk;

    p_unary_decode_pipe #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b1)) u_dut0 (
        .i_clk(clk), .i_arst_n(rst_n), .i_valid(in_v), .i_x(in_x),
        .o_ready(rdy[0]), .o_valid(ov[0]), .o_is_unary(oun[0]),
        .o_is_compl(oco[0]), .o_level(olv[0]), .i_ready(rdy_in)
`ifdef P_UNARY_DECODE_STATS_EN
        , .i_cnt_clr(cnt_clr), .o_cnt_adm(cadm[0]), .o_cnt_rej(crej[0])
`endif
    );

    p_unary_decode_pipe #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b0)) u_dut1 (
        .i_clk(clk), .i_arst_n(rst_n), .i_valid(in_v), .i_x(in_x),
        .o_ready(rdy[1]), .o_valid(ov[1]), .o_is_unary(oun[1]),
        .o_is_compl(oco[1]), .o_level(olv[1]), .i_ready(rdy_in)
`ifdef P_UNARY_DECODE_STATS_EN
        , .i_cnt_clr(cnt_clr), .o_cnt_adm(cadm[1]), .o_cnt_rej(crej[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: admitted iff the (optionally inverted) word equals 2^k-1.
    function automatic logic [4:0] ref_dec(input logic [7:0] x, input bit en);
        logic [7:0] v;
        v = (en && x[7]) ? ~x : x;
        for (int k = 0; k < 8; k++) begin
            if (v == 8'((1 << k) - 1)) return {1'b1, en && x[7], 3'(k)};
        end
        return 5'd0;
    endfunction

    task automatic drive(input logic v, input logic [7:0] x, input logic r);
        @(posedge clk);
        #1;
        in_v   = v;
        in_x   = x;
        rdy_in = r;
    endtask

    // Scoreboard: predict transfers at the coming edge from negedge values.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                stl[d]  = 1'b0;
                held[d] = '0;
`ifdef P_UNARY_DECODE_STATS_EN
                m_adm[d] = '0;
                m_rej[d] = '0;
`endif
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                automatic logic [4:0] got = {oun[d], oco[d], olv[d]};
                automatic logic [4:0] exp = 5'd0;
                automatic bit popped = 1'b0;
                automatic int sz = q[d].size();
                chk($sformatf("ready%0d", d), 64'(rdy[d]), 64'(!(sz == 2 && !rdy_in)));
                if (sz == 0) chk($sformatf("idle_valid%0d", d), 64'(ov[d]), 64'd0);
                if (stl[d]) chk($sformatf("stall_hold%0d", d), 64'({ov[d], got}), 64'(held[d]));
                stl[d]  = ov[d] && !rdy_in;
                held[d] = {ov[d], got};
                if (ov[d] && rdy_in && sz > 0) begin
                    exp    = q[d].pop_front();
                    popped = 1'b1;
                    chk($sformatf("result%0d", d), 64'(got), 64'(exp));
                end
`ifdef P_UNARY_DECODE_STATS_EN
                chk($sformatf("cnt_adm%0d", d), 64'(cadm[d]), 64'(m_adm[d]));
                chk($sformatf("cnt_rej%0d", d), 64'(crej[d]), 64'(m_rej[d]));
                if (cnt_clr) begin
                    m_adm[d] = '0;
                    m_rej[d] = '0;
                end else if (popped) begin
                    if (exp[4]) begin
                        if (m_adm[d] != 32'hFFFF_FFFF) m_adm[d] = m_adm[d] + 32'd1;
                    end else begin
                        if (m_rej[d] != 32'hFFFF_FFFF) m_rej[d] = m_rej[d] + 32'd1;
                    end
                end
`endif
                if (in_v && rdy[d]) q[d].push_back(ref_dec(in_x, d == 0));
            end
        end
    end

    // Three back-to-back words; results expected on cycles N+2..N+4.
    task automatic stream3(input logic [23:0] ws, input logic [14:0] e0, input logic [14:0] e1);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, ws[23-8*i -: 8], 1'b1);
            else       drive(1'b0, 8'h00, 1'b1);
            @(negedge clk);
            if (i >= 2) begin
                chk("s3_valid", 64'(ov[0]), 64'd1);
                chk("s3_dut0", 64'({oun[0], oco[0], olv[0]}), 64'(e0[14-5*(i-2) -: 5]));
                chk("s3_dut1", 64'({oun[1], oco[1], olv[1]}), 64'(e1[14-5*(i-2) -: 5]));
            end else begin
                chk("s3_lat", 64'(ov[0]), 64'd0);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("s3_drained", 64'(ov[0]), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int acc = 0;
        rst_n = 1'b0; in_v = 1'b0; in_x = '0; rdy_in = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(ov[0]), 64'd0);
        chk("rst_payload", 64'({oun[0], oco[0], olv[0]}), 64'd0);
        chk("rst_ready", 64'(rdy[0]), 64'd1);
        #2 rst_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b1);

        // Normal-form words, then complimented and rejected words.
        stream3({8'h00, 8'h07, 8'h7F}, {5'b10000, 5'b10011, 5'b10111},
                {5'b10000, 5'b10011, 5'b10111});
        stream3({8'hF8, 8'hFF, 8'h05}, {5'b11011, 5'b11000, 5'b00000},
                {5'b00000, 5'b00000, 5'b00000});

        // Downstream stall with continuous input offers.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'((1 << (i + 1)) - 1), 1'b0);
            @(negedge clk);
            if (in_v && rdy[0]) acc++;
        end
        chk("stall_acc", 64'(acc), 64'd2);
        repeat (4) drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("stall_drained", 64'(ov[0]), 64'd0);

        // Randomised traffic biased towards unary and complimented words.
        for (int n = 0; n < 3000; n++) begin
            automatic int sel = int'($urandom % 4);
            automatic logic [7:0] w = 8'($urandom);
            automatic logic [7:0] u = 8'((1 << ($urandom % 8)) - 1);
            if (sel == 1) w = u;
            if (sel == 2) w = ~u;
            drive(($urandom % 4) != 0, w, ($urandom % 3) != 0);
`ifdef P_UNARY_DECODE_STATS_EN
            cnt_clr = (($urandom % 64) == 0);
`endif
        end
        cnt_clr = 1'b0;
        repeat (4) drive(1'b0, 8'h00, 1'b1);

        // Asynchronous reset with both stages full.
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h0F, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("full_valid", 64'(ov[0]), 64'd1);
        chk("full_ready", 64'(rdy[0]), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid0", 64'(ov[0]), 64'd0);
        chk("async_valid1", 64'(ov[1]), 64'd0);
        rdy_in = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(rdy[0]), 64'd1);
        chk("post_rst_valid", 64'(ov[0]), 64'd0);
        repeat (3) drive(1'b0, 8'h00, 1'b1);

`ifdef P_UNARY_DECODE_STATS_EN
        begin
            automatic logic [7:0] words [13] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                                 8'h1F, 8'h3F, 8'h7F, 8'h00, 8'h01,
                                                 8'h05, 8'h0A, 8'h06};
            foreach (words[i]) drive(1'b1, words[i], 1'b1);
            repeat (3) drive(1'b0, 8'h00, 1'b1);
            @(negedge clk);
            chk("stats_adm", 64'(cadm[0]), 64'd10);
            chk("stats_rej", 64'(crej[0]), 64'd3);
            drive(1'b1, 8'h07, 1'b1);
            drive(1'b0, 8'h00, 1'b1);
            drive(1'b0, 8'h00, 1'b1);
            cnt_clr = 1'b1;
            @(negedge clk);
            chk("clr_xfer_valid", 64'(ov[0]), 64'd1);
            drive(1'b0, 8'h00, 1'b1);
            cnt_clr = 1'b0;
            @(negedge clk);
            chk("clr_adm", 64'(cadm[0]), 64'd0);
            chk("clr_rej", 64'(crej[0]), 64'd0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
